// File: rtl/video_frame_capture.sv
// Clocked-video capture: measures active frame size, locks on two equal frames and
// streams each locked frame as an Avalon-ST packet through a small FIFO.
module video_frame_capture #(
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 11
) (
  input  logic              i_video_clk,
  input  logic              i_rst,
  input  logic              i_vid_hs,
  input  logic              i_vid_vs,
  input  logic              i_vid_de,
  input  logic [DATA_W-1:0] i_vid_data,
  input  logic              i_st_ready,
  output logic              o_st_valid,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_st_sop,
  output logic              o_st_eop,
  output logic              o_locked,
  output logic [CNT_W-1:0]  o_frame_width,
  output logic [CNT_W-1:0]  o_frame_height,
  output logic              o_err_overflow,
  output logic              o_err_size,
  input  logic              i_clr_status
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W = DATA_W + 2;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [2:0] S_UNLOCKED = 3'd0;
  localparam logic [2:0] S_WAIT_VS  = 3'd1;
  localparam logic [2:0] S_WAIT_DE  = 3'd2;
  localparam logic [2:0] S_STREAM   = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;

  logic              r_hs_q, r_vs_q, r_vs_qq, r_de_q, r_de_qq;
  logic [DATA_W-1:0] r_data_q;
  logic [CNT_W-1:0]  r_meas_x, r_meas_lines, r_cur_w, r_prev_w, r_prev_h;
  logic              r_incons, r_seen_vs, r_prev_valid, r_locked;
  logic [CNT_W-1:0]  r_frame_w, r_frame_h, r_x, r_y;
  logic [2:0]        r_state;
  logic              r_eop_seen, r_err_ov, r_err_sz;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              w_vs_edge, w_de_fall, w_cur_ok, w_lock_next, w_pop, w_can_push, w_last;
  logic              w_push, w_set_ov, w_set_sz, w_eop_seen_nxt, w_unused;
  logic [2:0]        w_state_nxt;
  logic [ENT_W-1:0]  w_push_data, w_head;
  logic [CNT_W-1:0]  w_x_nxt, w_y_nxt;

  assign w_unused  = r_hs_q;
  assign w_vs_edge = r_vs_q & ~r_vs_qq;
  assign w_de_fall = r_de_qq & ~r_de_q;
  assign w_cur_ok  = r_seen_vs & ~r_incons & (r_meas_lines != '0);
  assign w_lock_next = w_cur_ok & r_prev_valid & (r_cur_w == r_prev_w) & (r_meas_lines == r_prev_h);
  assign w_pop      = (r_count != '0) & i_st_ready;
  assign w_can_push = (r_count != FULL_CNT) | w_pop;
  assign w_last     = (r_x == r_frame_w - CNT_W'(1)) && (r_y == r_frame_h - CNT_W'(1));
  assign w_head     = r_mem[r_rd_ptr];

  assign o_st_valid     = (r_count != '0);
  assign o_st_data      = o_st_valid ? w_head[DATA_W-1:0] : '0;
  assign o_st_eop       = o_st_valid & w_head[DATA_W];
  assign o_st_sop       = o_st_valid & w_head[DATA_W+1];
  assign o_locked       = r_locked;
  assign o_frame_width  = r_frame_w;
  assign o_frame_height = r_frame_h;
  assign o_err_overflow = r_err_ov;
  assign o_err_size     = r_err_sz;

  // Input capture stage
  always_ff @(posedge i_video_clk) begin
    if (i_rst) begin
      r_hs_q <= 1'b0; r_vs_q <= 1'b0; r_vs_qq <= 1'b0;
      r_de_q <= 1'b0; r_de_qq <= 1'b0; r_data_q <= '0;
    end else begin
      r_hs_q <= i_vid_hs; r_vs_q <= i_vid_vs; r_vs_qq <= r_vs_q;
      r_de_q <= i_vid_de; r_de_qq <= r_de_q; r_data_q <= i_vid_data;
    end
  end

  // Frame measurement and lock decision, committed at each VS edge
  always_ff @(posedge i_video_clk) begin
    if (i_rst) begin
      r_meas_x <= '0; r_meas_lines <= '0; r_cur_w <= '0; r_incons <= 1'b0;
      r_seen_vs <= 1'b0; r_prev_w <= '0; r_prev_h <= '0; r_prev_valid <= 1'b0;
      r_locked <= 1'b0; r_frame_w <= '0; r_frame_h <= '0;
    end else if (w_vs_edge) begin
      r_meas_x     <= '0;
      r_meas_lines <= '0;
      r_incons     <= 1'b0;
      r_seen_vs    <= 1'b1;
      r_prev_w     <= r_cur_w;
      r_prev_h     <= r_meas_lines;
      r_prev_valid <= w_cur_ok;
      r_locked     <= w_lock_next;
      if (!r_locked) begin
        r_frame_w <= r_cur_w;
        r_frame_h <= r_meas_lines;
      end
    end else if (r_de_q) begin
      r_meas_x <= r_meas_x + CNT_W'(1);
    end else if (w_de_fall) begin
      r_meas_x     <= '0;
      r_meas_lines <= r_meas_lines + CNT_W'(1);
      if (r_meas_lines == '0) r_cur_w <= r_meas_x;
      else if (r_meas_x != r_cur_w) r_incons <= 1'b1;
    end
  end

  // Packetiser next-state and FIFO write decision
  always_comb begin
    w_state_nxt    = r_state;
    w_push         = 1'b0;
    w_push_data    = '0;
    w_set_ov       = 1'b0;
    w_set_sz       = 1'b0;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_eop_seen_nxt = r_eop_seen;
    case (r_state)
      S_UNLOCKED: if (w_vs_edge && w_lock_next) w_state_nxt = S_WAIT_DE;
      S_WAIT_VS: begin
        if (w_vs_edge) w_state_nxt = w_lock_next ? S_WAIT_DE : S_UNLOCKED;
        else if (r_de_q && r_eop_seen) w_set_sz = 1'b1;
      end
      S_WAIT_DE, S_STREAM: begin
        if (w_vs_edge) begin
          if (r_state == S_STREAM) begin
            w_set_sz    = 1'b1;
            w_state_nxt = S_FLUSH;
          end else if (!w_lock_next) begin
            w_state_nxt = S_UNLOCKED;
          end
        end else if (r_de_q) begin
          if (w_can_push) begin
            w_push      = 1'b1;
            w_push_data = {(r_state == S_WAIT_DE), w_last, r_data_q};
            if (r_x == r_frame_w - CNT_W'(1)) begin
              w_x_nxt = '0;
              w_y_nxt = r_y + CNT_W'(1);
            end else begin
              w_x_nxt = r_x + CNT_W'(1);
            end
            w_eop_seen_nxt = w_last;
            w_state_nxt    = w_last ? S_WAIT_VS : S_STREAM;
          end else begin
            // A dropped sop opens no packet, so only a started packet needs a filler
            w_set_ov    = 1'b1;
            w_state_nxt = (r_state == S_STREAM) ? S_FLUSH : S_WAIT_VS;
          end
        end
      end
      S_FLUSH: begin
        if (w_can_push) begin
          w_push      = 1'b1;
          w_push_data = {1'b0, 1'b1, DATA_W'(0)};
          if (w_vs_edge) w_state_nxt = w_lock_next ? S_WAIT_DE : S_UNLOCKED;
          else           w_state_nxt = r_locked ? S_WAIT_VS : S_UNLOCKED;
        end
      end
      default: w_state_nxt = S_UNLOCKED;
    endcase
    if (w_vs_edge) w_eop_seen_nxt = 1'b0;
  end

  // Packetiser state and position counters
  always_ff @(posedge i_video_clk) begin
    if (i_rst) begin
      r_state <= S_UNLOCKED; r_x <= '0; r_y <= '0; r_eop_seen <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_eop_seen <= w_eop_seen_nxt;
      r_x        <= (w_state_nxt == S_STREAM) ? w_x_nxt : '0;
      r_y        <= (w_state_nxt == S_STREAM) ? w_y_nxt : '0;
    end
  end

  // Sticky status; a new error in the clearing cycle wins
  always_ff @(posedge i_video_clk) begin
    if (i_rst) begin
      r_err_ov <= 1'b0; r_err_sz <= 1'b0;
    end else begin
      if (w_set_ov) r_err_ov <= 1'b1;
      else if (i_clr_status) r_err_ov <= 1'b0;
      if (w_set_sz) r_err_sz <= 1'b1;
      else if (i_clr_status) r_err_sz <= 1'b0;
    end
  end

  always_ff @(posedge i_video_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  // FIFO pointers; push and pop together when full is allowed
  always_ff @(posedge i_video_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_pop) r_count <= r_count - (PTR_W+1)'(1);
    end
  end
endmodule

// File: tb/tb_video_frame_capture.sv
// Directed bench for video_frame_capture: lock, streaming, overflow, size error, reset, status clear.
module tb_video_frame_capture;
  logic        clk = 1'b0;
  logic        i_rst, i_vid_hs, i_vid_vs, i_vid_de, i_st_ready, i_clr_status;
  logic [23:0] i_vid_data;
  logic        o_st_valid, o_st_sop, o_st_eop, o_locked, o_err_overflow, o_err_size;
  logic [23:0] o_st_data;
  logic [10:0] o_frame_width, o_frame_height;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 1'b0;
  logic [25:0] q[$];

  video_frame_capture dut (
    .i_video_clk(clk), .i_rst(i_rst), .i_vid_hs(i_vid_hs), .i_vid_vs(i_vid_vs),
    .i_vid_de(i_vid_de), .i_vid_data(i_vid_data), .i_st_ready(i_st_ready),
    .o_st_valid(o_st_valid), .o_st_data(o_st_data), .o_st_sop(o_st_sop), .o_st_eop(o_st_eop),
    .o_locked(o_locked), .o_frame_width(o_frame_width), .o_frame_height(o_frame_height),
    .o_err_overflow(o_err_overflow), .o_err_size(o_err_size), .i_clr_status(i_clr_status)
  );

  always #5 clk = ~clk;

  // Beats that will transfer at the next rising edge
  always @(negedge clk) begin
    if (!i_rst && o_st_valid && i_st_ready) q.push_back({o_st_sop, o_st_eop, o_st_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) i_st_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // VS pulse (closes the previous frame), then h lines of w pixels
  task automatic send_frame(input int w, input int h, input int gap, input int base,
                            input int stop_after, input int clr_at);
    int n;
    n = 0;
    i_vid_vs = 1'b1; tick(); tick(); i_vid_vs = 1'b0;
    idle(4);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (n == stop_after) begin
          i_vid_de = 1'b0;
          return;
        end
        i_vid_de     = 1'b1;
        i_vid_data   = 24'(base + y * 256 + x);
        i_clr_status = (n == clr_at);
        tick();
        n++;
      end
      i_vid_de = 1'b0; i_clr_status = 1'b0; i_vid_hs = 1'b1;
      tick();
      i_vid_hs = 1'b0;
      idle(gap);
    end
  endtask

  task automatic check_beats(input string tag, input int npix, input int w, input int base,
                             input bit filler);
    int exp_n;
    logic [25:0] e;
    exp_n = npix + (filler ? 1 : 0);
    chk({tag, "_count"}, 32'(q.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < q.size(); i++) begin
      if (filler && i == npix) e = {1'b0, 1'b1, 24'h0};
      else e = {(i == 0), (!filler && i == npix - 1), 24'(base + (i / w) * 256 + (i % w))};
      chk($sformatf("%s_beat%0d", tag, i), 32'(q[i]), 32'(e));
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1; i_vid_vs = 1'b0; i_vid_de = 1'b0; i_vid_hs = 1'b0;
    i_clr_status = 1'b0; i_vid_data = '0;
    idle(3);
    i_rst = 1'b0;
    tick();
  endtask

  initial begin
    i_st_ready = 1'b1;
    do_reset();
    chk("rst_valid", 32'(o_st_valid), 0);
    chk("rst_locked", 32'(o_locked), 0);
    chk("rst_width", 32'(o_frame_width), 0);
    chk("rst_height", 32'(o_frame_height), 0);
    chk("rst_err_ov", 32'(o_err_overflow), 0);
    chk("rst_err_sz", 32'(o_err_size), 0);

    // T1: lock on 4x3 and stream the third frame
    send_frame(4, 3, 3, 'h010000, -1, -1);
    send_frame(4, 3, 3, 'h020000, -1, -1);
    chk("t1_unlocked_f2", 32'(o_locked), 0);
    q.delete();
    send_frame(4, 3, 3, 'h030000, -1, -1);
    idle(10);
    chk("t1_locked", 32'(o_locked), 1);
    chk("t1_width", 32'(o_frame_width), 4);
    chk("t1_height", 32'(o_frame_height), 3);
    check_beats("t1", 12, 4, 'h030000, 1'b0);

    // T2: random backpressure with long line blanking
    q.delete();
    rand_ready = 1'b1;
    send_frame(4, 3, 20, 'h040000, -1, -1);
    rand_ready = 1'b0; i_st_ready = 1'b1;
    idle(20);
    check_beats("t2", 12, 4, 'h040000, 1'b0);
    chk("t2_err_ov", 32'(o_err_overflow), 0);
    chk("t2_locked", 32'(o_locked), 1);

    // T5: reset after 5 pixels of a streamed frame, relock needs two full frames
    send_frame(4, 3, 3, 'h050000, 5, -1);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk("t5_valid", 32'(o_st_valid), 0);
    chk("t5_locked", 32'(o_locked), 0);
    tick();
    chk("t5_valid_after", 32'(o_st_valid), 0);
    q.delete();
    send_frame(4, 3, 3, 'h060000, -1, -1);
    chk("t5_unlocked_a", 32'(o_locked), 0);
    send_frame(4, 3, 3, 'h070000, -1, -1);
    chk("t5_unlocked_b", 32'(o_locked), 0);
    chk("t5_no_beats", 32'(q.size()), 0);
    send_frame(4, 3, 3, 'h080000, -1, -1);
    idle(10);
    chk("t5_relocked", 32'(o_locked), 1);
    check_beats("t5", 12, 4, 'h080000, 1'b0);
    chk("t5_err_sz", 32'(o_err_size), 0);

    // T4: short frame (2 lines) is closed with a filler and drops lock
    q.delete();
    send_frame(4, 2, 3, 'h090000, -1, -1);
    send_frame(4, 3, 3, 'h0A0000, -1, -1);
    idle(10);
    check_beats("t4", 8, 4, 'h090000, 1'b1);
    chk("t4_err_sz", 32'(o_err_size), 1);
    chk("t4_locked", 32'(o_locked), 0);
    q.delete();
    send_frame(4, 3, 3, 'h0B0000, -1, -1);
    idle(10);
    chk("t4_not_streamed", 32'(q.size()), 0);
    chk("t4_still_unlocked", 32'(o_locked), 0);

    // T3: locked 8x4 with the sink stalled for a whole frame
    do_reset();
    send_frame(8, 4, 3, 'h0C0000, -1, -1);
    send_frame(8, 4, 3, 'h0D0000, -1, -1);
    q.delete();
    i_st_ready = 1'b0;
    send_frame(8, 4, 3, 'h0E0000, -1, -1);
    idle(5);
    chk("t3_locked", 32'(o_locked), 1);
    chk("t3_width", 32'(o_frame_width), 8);
    chk("t3_height", 32'(o_frame_height), 4);
    chk("t3_err_ov", 32'(o_err_overflow), 1);
    chk("t3_stalled", 32'(q.size()), 0);
    i_st_ready = 1'b1;
    idle(30);
    check_beats("t3", 16, 8, 'h0E0000, 1'b1);

    // T6: clear alone, then clear coinciding with a new overflow
    i_clr_status = 1'b1; tick(); i_clr_status = 1'b0;
    chk("t6_clr_alone", 32'(o_err_overflow), 0);
    q.delete();
    i_st_ready = 1'b0;
    send_frame(8, 4, 3, 'h0F0000, -1, 17);
    chk("t6_set_wins", 32'(o_err_overflow), 1);
    i_clr_status = 1'b1; tick(); i_clr_status = 1'b0;
    chk("t6_cleared", 32'(o_err_overflow), 0);
    i_st_ready = 1'b1;
    idle(30);
    check_beats("t6", 16, 8, 'h0F0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
